heading_pid: RTL

HEADING_PID -- requirements
Module: heading_pid

---
 rtl/heading_pid.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/heading_pid.sv
// heading_pid - heading-hold PID controller for a differential-drive robot.
//
// Two-stage pipeline:
//   stage 1 (edge after hdng_vld): saturated heading error, at_hdng flag,
//            integrator update, optional derivative difference.
//   stage 2 (one edge later): PID sum, motor speed mix with saturation,
//            out_vld pulse.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   moving     robot moving; low clears integrator / derivative history
//   hdng_vld   one-cycle pulse, new heading sample
//   heading    12-bit signed current heading
//   dsrd_hdng  12-bit signed desired heading
//   frwrd_spd  11-bit unsigned base forward speed
//   lft_spd    12-bit signed left motor command (registered)
//   rght_spd   12-bit signed right motor command (registered)
//   at_hdng    registered, |err_sat| < 30
//   out_vld    one-cycle pulse, speeds just updated
//
// Build option
//   HEADING_PID_DTERM_EN  when defined, adds the derivative term
//                         (prev_err history register, D = sat8(err - prev)*4).
//                         When undefined, D_term is zero and no history is kept.

module heading_pid (
    input  logic        clk,
    input  logic        rst,
    input  logic        moving,
    input  logic        hdng_vld,
    input  logic [11:0] heading,
    input  logic [11:0] dsrd_hdng,
    input  logic [10:0] frwrd_spd,
    output logic [11:0] lft_spd,
    output logic [11:0] rght_spd,
    output logic        at_hdng,
    output logic        out_vld
);

    // ---------------- stage 1 combinational ----------------
    logic signed [12:0] err_raw;
    logic signed [9:0]  err_nxt;
    logic               at_nxt;
    logic signed [16:0] integ_sum;
    logic signed [15:0] integ_nxt;

    // ---------------- stage 1 registers ----------------
    logic               vld1;
    logic               mov1;
    logic signed [9:0]  err_sat;
    logic signed [15:0] integ;

    always_comb begin
        err_raw = $signed({heading[11], heading}) - $signed({dsrd_hdng[11], dsrd_hdng});
        if (err_raw > 13'sd511)
            err_nxt = 10'sd511;
        else if (err_raw < -13'sd512)
            err_nxt = -10'sd512;
        else
            err_nxt = err_raw[9:0];

        at_nxt = (err_nxt > -10'sd30) && (err_nxt < 10'sd30);

        integ_sum = $signed({integ[15], integ}) + $signed({{7{err_nxt[9]}}, err_nxt});
        if (integ_sum > 17'sd32767)
            integ_nxt = 16'sh7FFF;
        else if (integ_sum < -17'sd32768)
            integ_nxt = 16'sh8000;
        else
            integ_nxt = integ_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld1    <= 1'b0;
            mov1    <= 1'b0;
            err_sat <= '0;
            at_hdng <= 1'b0;
            integ   <= '0;
        end else begin
            vld1 <= hdng_vld;
            if (hdng_vld) begin
                // moving travels with the sample so an in-flight sample
                // taken while moving keeps its command even if moving drops.
                mov1    <= moving;
                err_sat <= err_nxt;
                at_hdng <= at_nxt;
            end
            if (!moving)
                integ <= '0;
            else if (hdng_vld)
                integ <= integ_nxt;
        end
    end

    // ---------------- derivative term ----------------
    logic signed [13:0] d_term;

`ifdef HEADING_PID_DTERM_EN
    logic signed [9:0]  prev_err;
    logic signed [10:0] d_raw;
    logic signed [7:0]  d_nxt;
    logic signed [7:0]  d_diff;

    // The difference is formed against prev_err before it is overwritten
    // by the same sample, then carried into stage 2 as d_diff.
    always_comb begin
        d_raw = $signed({err_nxt[9], err_nxt}) - $signed({prev_err[9], prev_err});
        if (d_raw > 11'sd127)
            d_nxt = 8'sd127;
        else if (d_raw < -11'sd128)
            d_nxt = -8'sd128;
        else
            d_nxt = d_raw[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_err <= '0;
            d_diff   <= '0;
        end else begin
            if (!moving)
                prev_err <= '0;
            else if (hdng_vld)
                prev_err <= err_nxt;
            if (hdng_vld)
                d_diff <= d_nxt;
        end
    end

    assign d_term = $signed({{4{d_diff[7]}}, d_diff, 2'b00});
`else
    assign d_term = '0;
`endif

    // ---------------- stage 2 ----------------
    logic signed [13:0] e14;
    logic signed [13:0] p_term;
    logic signed [15:0] i_ext;
    logic signed [15:0] pid_sum;
    logic signed [15:0] mix;
    logic signed [15:0] fwd;
    logic signed [15:0] lft_sum;
    logic signed [15:0] rght_sum;

    function automatic logic [11:0] sat12(input logic signed [15:0] v);
        if (v > 16'sd2047)
            return 12'h7FF;
        else if (v < -16'sd2048)
            return 12'h800;
        else
            return v[11:0];
    endfunction

    always_comb begin
        e14      = $signed({{4{err_sat[9]}}, err_sat});
        p_term   = (e14 <<< 2) + e14;
        i_ext    = integ >>> 6;
        pid_sum  = $signed({{2{p_term[13]}}, p_term}) + i_ext
                 + $signed({{2{d_term[13]}}, d_term});
        mix      = pid_sum >>> 3;
        fwd      = $signed({5'b00000, frwrd_spd});
        lft_sum  = fwd + mix;
        rght_sum = fwd - mix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            lft_spd  <= '0;
            rght_spd <= '0;
        end else begin
            out_vld <= vld1;
            if (vld1) begin
                lft_spd  <= mov1 ? sat12(lft_sum)  : 12'h000;
                rght_spd <= mov1 ? sat12(rght_sum) : 12'h000;
            end else if (!moving) begin
                lft_spd  <= '0;
                rght_spd <= '0;
            end
        end
    end

endmodule
